// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   ADDR_W / DATA_W : default register address and data widths
//   NUM_REGS        : number of architectural registers
//   GID_W           : width of requester indices (up to 8 requesters)
//   CLR_W           : width of the power-up clear counter
//   CLR_END_ADDR    : last register written by the clear sequence
//   state_t         : FSM state type with constants CLEAR and RUN
package regfile_pkg;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned GID_W    = 3;
    localparam int unsigned CLR_W    = 5;

    localparam logic [CLR_W-1:0] CLR_END_ADDR = 5'd31;

    typedef logic [0:0] state_t;
    localparam state_t CLEAR = 1'b0;
    localparam state_t RUN   = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request searching upward
// from (last_grant_i + 1) mod NREQ, wrapping around.
//   req_i        : request vector
//   last_grant_i : index of the most recently granted requester (< NREQ)
//   gnt_o        : one-hot grant, all-zero when nothing is requested
//   idx_o        : encoded index of the granted requester (0 when none)
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned NREQ = 3
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [GID_W-1:0] last_grant_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [GID_W-1:0] idx_o
);

    always_comb begin
        int unsigned cand;
        logic        found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            // last_grant_i < NREQ and off <= NREQ, so one subtraction wraps
            cand = int'(last_grant_i) + off;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                gnt_o[cand]  = 1'b1;
                idx_o        = GID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port among NREQ writeback
// requesters. After reset an optional clear sequence writes zero to
// registers 1..31, then requests are served round-robin, one per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_valid  : per-requester write request
//   req_addr   : packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data   : packed data, same packing
//   req_ready  : one-hot grant (combinational)
//   A3/WD3/WE3 : registered register-file write port
//   busy       : high while the clear sequence runs
//   grant_id   : registered index of the last accepted requester
module regfile_write_arbiter #(
    parameter int unsigned NREQ           = 3,
    parameter int unsigned ADDR_W         = regfile_pkg::ADDR_W,
    parameter int unsigned DATA_W         = regfile_pkg::DATA_W,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ*ADDR_W-1:0]        req_addr,
    input  logic [NREQ*DATA_W-1:0]        req_data,
    output logic [NREQ-1:0]               req_ready,
    output logic [ADDR_W-1:0]             A3,
    output logic [DATA_W-1:0]             WD3,
    output logic                          WE3,
    output logic                          busy,
    output logic [regfile_pkg::GID_W-1:0] grant_id
);
    import regfile_pkg::*;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

    state_t            state_q, state_d;
    logic [CLR_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic [GID_W-1:0]  last_grant_q, last_grant_d;
    logic [GID_W-1:0]  grant_id_q, grant_id_d;
    logic [ADDR_W-1:0] a3_q, a3_d;
    logic [DATA_W-1:0] wd3_q, wd3_d;
    logic              we3_q, we3_d;

    logic [NREQ-1:0]   gnt;
    logic [GID_W-1:0]  gnt_idx;
    logic              accept;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .gnt_o        (gnt),
        .idx_o        (gnt_idx)
    );

    // rst_n gating only matters when the FSM resets straight into RUN
    assign req_ready = (rst_n && state_q == RUN) ? gnt : '0;
    // Acceptance is derived from the arbiter directly so no state flop
    // takes rst_n as data.
    assign accept    = (state_q == RUN) && (|(req_valid & gnt));
    assign sel_addr  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    assign sel_data  = req_data[int'(gnt_idx)*DATA_W +: DATA_W];

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        a3_d         = a3_q;
        wd3_d        = wd3_q;
        we3_d        = 1'b0;
        case (state_q)
            CLEAR: begin
                we3_d     = 1'b1;
                a3_d      = ADDR_W'(clr_cnt_q);
                wd3_d     = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == CLR_END_ADDR) begin
                    state_d = RUN;
                end
            end
            default: begin
                if (accept) begin
                    a3_d         = sel_addr;
                    wd3_d        = sel_data;
                    // register 0 is hardwired; complete the handshake only
                    we3_d        = (sel_addr != '0);
                    grant_id_d   = gnt_idx;
                    last_grant_d = gnt_idx;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RESET_STATE;
            clr_cnt_q    <= CLR_W'(1);
            last_grant_q <= GID_W'(NREQ - 1);
            grant_id_q   <= '0;
            a3_q         <= '0;
            wd3_q        <= '0;
            we3_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            a3_q         <= a3_d;
            wd3_q        <= wd3_d;
            we3_q        <= we3_d;
        end
    end

    assign A3       = a3_q;
    assign WD3      = wd3_q;
    assign WE3      = we3_q;
    assign grant_id = grant_id_q;
    assign busy     = (state_q == CLEAR);

endmodule
